// File: rtl/demux_sched_pkg.sv
// Shared constants for the demux lane scheduler: FSM encoding, lane ids, default widths.
package demux_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_STALL  = 2'd2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  function automatic logic other_lane(input logic lane);
    return ~lane;
  endfunction

endpackage

// File: rtl/lane_counter.sv
// CNT_W event counter with increment enable; sat_en selects saturate-at-all-ones instead of wrap.
module lane_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             sat_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // next count: hold, wrap-increment, or stick at all-ones
  always_comb begin
    count_nxt_s = count_r;
    if (!inc_en) begin
      count_nxt_s = count_r;
    end else if (sat_en && (count_r == {CNT_W{1'b1}})) begin
      count_nxt_s = count_r;
    end else begin
      count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/demux_lane_sched.sv
// Byte-by-byte lane alternation onto the two demux lanes with per-lane pause back-pressure.
// Optional macro LANE_SKIP_EN: route around a paused lane instead of waiting for it.
module demux_lane_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  input  logic              pause0,
  input  logic              pause1,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1,
  output logic              lane_ptr,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_r;
  state_t            next_state_s;
  logic              lane_ptr_r;
  logic              lane_sel_s;
  logic              ready_s;
  logic              xfer_s;
  logic [1:0]        pause_s;
  logic              validout0_r;
  logic              validout1_r;
  logic [DATA_W-1:0] dataout0_r;
  logic [DATA_W-1:0] dataout1_r;

  assign pause_s = {pause1, pause0};
  assign xfer_s  = valid_in && ready_s;

  // FSM state register
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; dropping enable always wins
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) next_state_s = ST_ACTIVE;
        else        next_state_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!enable)                 next_state_s = ST_IDLE;
        else if (valid_in && !ready_s) next_state_s = ST_STALL;
        else                         next_state_s = ST_ACTIVE;
      end
      ST_STALL: begin
        if (!enable)                  next_state_s = ST_IDLE;
        else if (xfer_s || !valid_in) next_state_s = ST_ACTIVE;
        else                          next_state_s = ST_STALL;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: ready and lane selection (enable gates ready so a falling enable blocks the edge)
  always_comb begin
    lane_sel_s = lane_ptr_r;
    ready_s    = 1'b0;
`ifdef LANE_SKIP_EN
    if (pause_s[lane_ptr_r] && !pause_s[other_lane(lane_ptr_r)]) begin
      lane_sel_s = other_lane(lane_ptr_r);
    end else begin
      lane_sel_s = lane_ptr_r;
    end
    if ((state_r != ST_IDLE) && enable && !(pause0 && pause1)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
`else
    if ((state_r != ST_IDLE) && enable && !pause_s[lane_ptr_r]) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
`endif
  end

  // lane data/strobe registers and next-lane pointer (pointer survives IDLE)
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      lane_ptr_r  <= LANE0;
      validout0_r <= 1'b0;
      validout1_r <= 1'b0;
      dataout0_r  <= {DATA_W{1'b0}};
      dataout1_r  <= {DATA_W{1'b0}};
    end else begin
      validout0_r <= xfer_s && (lane_sel_s == LANE0);
      validout1_r <= xfer_s && (lane_sel_s == LANE1);
      if (xfer_s && (lane_sel_s == LANE0)) dataout0_r <= data_in;
      else                                 dataout0_r <= dataout0_r;
      if (xfer_s && (lane_sel_s == LANE1)) dataout1_r <= data_in;
      else                                 dataout1_r <= dataout1_r;
      if (xfer_s) lane_ptr_r <= other_lane(lane_sel_s);
      else        lane_ptr_r <= lane_ptr_r;
    end
  end

  lane_counter #(.CNT_W(CNT_W)) u_count0 (
    .clk    (clk_4f),
    .rst_n  (reset_L),
    .inc_en (xfer_s && (lane_sel_s == LANE0)),
    .sat_en (1'b0),
    .count  (count0)
  );

  lane_counter #(.CNT_W(CNT_W)) u_count1 (
    .clk    (clk_4f),
    .rst_n  (reset_L),
    .inc_en (xfer_s && (lane_sel_s == LANE1)),
    .sat_en (1'b0),
    .count  (count1)
  );

  lane_counter #(.CNT_W(CNT_W)) u_stall (
    .clk    (clk_4f),
    .rst_n  (reset_L),
    .inc_en (state_r == ST_STALL),
    .sat_en (1'b1),
    .count  (stall_cnt)
  );

  assign ready_out = ready_s;
  assign validout0 = validout0_r;
  assign validout1 = validout1_r;
  assign dataout0  = dataout0_r;
  assign dataout1  = dataout1_r;
  assign lane_ptr  = lane_ptr_r;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Directed bench for demux_lane_sched; builds for strict or LANE_SKIP_EN mode.
module tb_demux_lane_sched;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       enable;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;
  logic       pause0;
  logic       pause1;
  logic       validout0;
  logic       validout1;
  logic [7:0] dataout0;
  logic [7:0] dataout1;
  logic       lane_ptr;
  logic [7:0] count0;
  logic [7:0] count1;
  logic [7:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  demux_lane_sched #(.DATA_W(8), .CNT_W(8)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .enable    (enable),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .pause0    (pause0),
    .pause1    (pause1),
    .validout0 (validout0),
    .validout1 (validout1),
    .dataout0  (dataout0),
    .dataout1  (dataout1),
    .lane_ptr  (lane_ptr),
    .count0    (count0),
    .count1    (count1),
    .stall_cnt (stall_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " ready"},    {31'd0, ready_out}, 32'd0);
    check_eq({tag, " vout0"},    {31'd0, validout0}, 32'd0);
    check_eq({tag, " vout1"},    {31'd0, validout1}, 32'd0);
    check_eq({tag, " dout0"},    {24'd0, dataout0},  32'd0);
    check_eq({tag, " dout1"},    {24'd0, dataout1},  32'd0);
    check_eq({tag, " ptr"},      {31'd0, lane_ptr},  32'd0);
    check_eq({tag, " count0"},   {24'd0, count0},    32'd0);
    check_eq({tag, " count1"},   {24'd0, count1},    32'd0);
    check_eq({tag, " stall"},    {24'd0, stall_cnt}, 32'd0);
  endtask

  logic [7:0] stream_bytes [4];

`ifdef LANE_SKIP_EN
  localparam logic [7:0] EXP_STALL_T4 = 8'd1;
  localparam logic       EXP_PTR_T4   = 1'b1;
  localparam logic [7:0] EXP_CNT0_T5  = 8'd0;
`else
  localparam logic [7:0] EXP_STALL_T4 = 8'd4;
  localparam logic       EXP_PTR_T4   = 1'b0;
  localparam logic [7:0] EXP_CNT0_T5  = 8'd3;
`endif

  initial begin
    stream_bytes[0] = 8'h11;
    stream_bytes[1] = 8'h22;
    stream_bytes[2] = 8'h33;
    stream_bytes[3] = 8'h44;
    reset_L  = 1'b0;
    enable   = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    pause0   = 1'b0;
    pause1   = 1'b0;

    #12;
    check_all_zero("reset");

    @(negedge clk_4f);
    reset_L = 1'b1;
    enable  = 1'b1;
    #1 check_eq("idle ready", {31'd0, ready_out}, 32'd0);

    // back-to-back stream alternates lanes
    @(negedge clk_4f);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in  = stream_bytes[i];
      #1;
      check_eq("stream ready", {31'd0, ready_out}, 32'd1);
      check_eq("stream ptr",   {31'd0, lane_ptr},  i % 2);
      @(negedge clk_4f);
      if (i % 2 == 0) begin
        check_eq("stream vout0", {31'd0, validout0}, 32'd1);
        check_eq("stream vout1", {31'd0, validout1}, 32'd0);
        check_eq("stream dout0", {24'd0, dataout0},  {24'd0, stream_bytes[i]});
      end else begin
        check_eq("stream vout1", {31'd0, validout1}, 32'd1);
        check_eq("stream vout0", {31'd0, validout0}, 32'd0);
        check_eq("stream dout1", {24'd0, dataout1},  {24'd0, stream_bytes[i]});
      end
    end
    valid_in = 1'b0;
    check_eq("stream count0", {24'd0, count0}, 32'd2);
    check_eq("stream count1", {24'd0, count1}, 32'd2);
    @(negedge clk_4f);
    check_eq("idle vout0", {31'd0, validout0}, 32'd0);
    check_eq("idle vout1", {31'd0, validout1}, 32'd0);
    check_eq("held dout0", {24'd0, dataout0},  32'h33);

    // one byte to lane0 so lane_ptr points at lane1
    valid_in = 1'b1;
    data_in  = 8'h55;
    @(negedge clk_4f);
    valid_in = 1'b0;
    check_eq("b55 vout0", {31'd0, validout0}, 32'd1);
    check_eq("b55 ptr",   {31'd0, lane_ptr},  32'd1);

    // lane1 paused while lane_ptr = 1
    pause1   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hA5;
`ifdef LANE_SKIP_EN
    #1 check_eq("skip ready", {31'd0, ready_out}, 32'd1);
    @(negedge clk_4f);
    valid_in = 1'b0;
    pause1   = 1'b0;
    check_eq("skip vout0",  {31'd0, validout0}, 32'd1);
    check_eq("skip vout1",  {31'd0, validout1}, 32'd0);
    check_eq("skip dout0",  {24'd0, dataout0},  32'hA5);
    check_eq("skip ptr",    {31'd0, lane_ptr},  32'd1);
    check_eq("skip stall",  {24'd0, stall_cnt}, 32'd0);
    check_eq("skip count0", {24'd0, count0},    32'd4);

    // lane0 wrap with lane1 paused throughout
    reset_L = 1'b0;
    #2 reset_L = 1'b1;
    @(negedge clk_4f);
    pause1   = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 256; i++) begin
      data_in = i[7:0];
      @(negedge clk_4f);
      if (i == 254) check_eq("wrap count0 255", {24'd0, count0}, 32'd255);
    end
    valid_in = 1'b0;
    pause1   = 1'b0;
    check_eq("wrap count0", {24'd0, count0},   32'd0);
    check_eq("wrap count1", {24'd0, count1},   32'd0);
    check_eq("wrap dout0",  {24'd0, dataout0}, 32'hFF);
    check_eq("wrap ptr",    {31'd0, lane_ptr}, 32'd1);
`else
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("strict ready", {31'd0, ready_out}, 32'd0);
      @(negedge clk_4f);
      check_eq("strict no vout", {30'd0, validout1, validout0}, 32'd0);
    end
    pause1 = 1'b0;
    #1 check_eq("release ready", {31'd0, ready_out}, 32'd1);
    @(negedge clk_4f);
    valid_in = 1'b0;
    check_eq("strict vout1",  {31'd0, validout1}, 32'd1);
    check_eq("strict dout1",  {24'd0, dataout1},  32'hA5);
    check_eq("strict stall",  {24'd0, stall_cnt}, 32'd3);
    check_eq("strict count1", {24'd0, count1},    32'd3);
    check_eq("strict ptr",    {31'd0, lane_ptr},  32'd0);
`endif

    // enable dropped while stalled
    pause0   = 1'b1;
    pause1   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'hC3;
    #1 check_eq("both paused ready", {31'd0, ready_out}, 32'd0);
    @(negedge clk_4f);
    enable = 1'b0;
    #1 check_eq("disable ready", {31'd0, ready_out}, 32'd0);
    @(negedge clk_4f);
    check_eq("disable vouts", {30'd0, validout1, validout0}, 32'd0);
    check_eq("disable ptr",   {31'd0, lane_ptr},  {31'd0, EXP_PTR_T4});
    check_eq("disable stall", {24'd0, stall_cnt}, {24'd0, EXP_STALL_T4});
    @(negedge clk_4f);
    check_eq("idle stall hold", {24'd0, stall_cnt}, {24'd0, EXP_STALL_T4});
    pause0   = 1'b0;
    pause1   = 1'b0;
    valid_in = 1'b0;
    enable   = 1'b1;
    #1 check_eq("reenable idle ready", {31'd0, ready_out}, 32'd0);

    // both lanes paused for 300 cycles
    pause0   = 1'b1;
    pause1   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    repeat (300) @(negedge clk_4f);
    check_eq("sat stall",  {24'd0, stall_cnt}, 32'hFF);
    check_eq("sat ready",  {31'd0, ready_out}, 32'd0);
    check_eq("sat count0", {24'd0, count0},    {24'd0, EXP_CNT0_T5});

    // asynchronous reset mid-stream
    pause0 = 1'b0;
    pause1 = 1'b0;
    data_in = 8'h77;
    @(posedge clk_4f);
    @(posedge clk_4f);
    #2 reset_L = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk_4f);
    check_all_zero("held reset");
    reset_L  = 1'b1;
    valid_in = 1'b0;
    @(negedge clk_4f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_lane_sched.md
# demux_lane_sched

Controller that sequences an 8-bit byte stream onto the two lanes of the 1-to-2 demux stage on the `clk_4f` domain. It alternates lanes byte by byte and honours per-lane pause (almost-full) from downstream FIFOs. It back-pressures the source with `ready_out` and exposes per-lane byte counters and a stall counter for observability. It sits between the serial-to-parallel front end and the lane FIFOs, replacing free-running lane alternation.

## Interface
Parameters:
- `DATA_W`, 8, byte width on the input and each lane.
- `CNT_W`, 8, width of the lane and stall counters.

Ports:
- `clk_4f`  in  1  clock; single clock domain.
- `reset_L`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  scheduler run enable.
- `valid_in`  in  1  source has a byte.
- `data_in`  in  DATA_W  source byte.
- `ready_out`  out  1  combinational; a transfer occurs on the edge where `valid_in && ready_out`.
- `pause0`, `pause1`  in  1 each  downstream lane almost-full; a paused lane must not receive a byte.
- `validout0`, `validout1`  out  1 each  registered lane strobe.
- `dataout0`, `dataout1`  out  DATA_W each  registered lane data.
- `lane_ptr`  out  1  lane targeted by the next transfer.
- `count0`, `count1`  out  CNT_W each  bytes delivered per lane.
- `stall_cnt`  out  CNT_W  cycles spent in STALL.

## Operation
States: IDLE, ACTIVE, STALL.

Transitions:
- IDLE → ACTIVE when `enable` = 1.
- Any state → IDLE when `enable` = 0. A pending byte is not accepted.
- ACTIVE → STALL when `valid_in` = 1 and `ready_out` = 0.
- STALL → ACTIVE on the edge where a transfer occurs or `valid_in` = 0.

Ready and routing:
- `ready_out` = state ≠ IDLE and the chosen lane is not paused.
- Chosen lane = `lane_ptr`.
- On transfer to lane L:
  - `dataoutL` ← `data_in`.
  - `validoutL` = 1 for exactly one cycle.
  - `countL` increments, wrapping modulo 2^CNT_W.
  - `lane_ptr` ← ~L.

Lane outputs:
- The non-selected lane's `validout` is 0.
- `dataout` holds its last value; it is not cleared.

Stall counter:
- `stall_cnt` increments every cycle the state is STALL.
- It saturates at all-ones.

Pointer retention:
- `lane_ptr` is retained across IDLE.
- Only reset returns it to 0.

Reset values (all outputs):
- State IDLE.
- `lane_ptr` = 0.
- `validout0/1` = 0, `dataout0/1` = 0.
- `count0/1` = 0, `stall_cnt` = 0.
- `ready_out` = 0.

## Timing
- Latency is one cycle: a byte accepted at edge N is on `dataoutL` with `validoutL` = 1 after edge N.
- Sustained throughput is one byte per cycle when no lane is paused.
- Pause sampling:
  - `pause0/1` are sampled combinationally into `ready_out` in the same cycle.
  - A pause asserted in cycle N blocks the transfer at edge N.
- `enable` falling in cycle N: no transfer at edge N, and IDLE from edge N.
- Reset assertion mid-transfer clears all registers immediately. The in-flight byte is lost.
- Both lanes paused: `ready_out` = 0 in every mode.

## Configuration
- `LANE_SKIP_EN` defined:
  - If `pause[lane_ptr]` = 1 and the other lane is not paused, route to the other lane M.
  - `lane_ptr` then ← ~M, i.e. unchanged.
  - `ready_out` = state ≠ IDLE and not (`pause0` and `pause1`).
- `LANE_SKIP_EN` undefined:
  - Strict alternation: wait in STALL for `lane_ptr` to unpause.

## Structure
- Shared package `demux_sched_pkg` holds:
  - State encoding constants `ST_IDLE`, `ST_ACTIVE`, `ST_STALL`.
  - Lane constants `LANE0` = 0, `LANE1` = 1.
  - Default widths.
- One natural sub-module, `lane_counter`: a CNT_W counter with increment enable and a wrap/saturate select. It is instantiated three times: two wrapping lane counters and one saturating stall counter.

## Test plan
- Reset then enable, stream 0x11, 0x22, 0x33, 0x44 back-to-back → lane0 gets 0x11, 0x33; lane1 gets 0x22, 0x44, each one cycle after acceptance; `count0` = `count1` = 2.
- `pause1` = 1 with `lane_ptr` = 1 for 3 cycles, `valid_in` held with 0xA5:
  - Strict: `ready_out` = 0 for those cycles; STALL; `stall_cnt` = 3; 0xA5 lands on lane1 after release.
  - `LANE_SKIP_EN`: 0xA5 goes to lane0 immediately; `stall_cnt` = 0.
- 256 bytes streamed to lane0 in skip mode with lane1 paused throughout → `count0` wraps to 0.
- `enable` dropped during STALL → IDLE next edge; no `validout` pulse; `lane_ptr` unchanged.
- `reset_L` asserted asynchronously mid-stream → all outputs 0 before the next `clk_4f` edge.
- Both lanes paused for 300 cycles with `valid_in` = 1 → `stall_cnt` saturates at 0xFF.
